// File: rtl/graphics_pkg.sv
// Shared graphics definitions: tile IDs, tile size, playback sequencer
// state encoding and the per-step flash hold calculation.
package graphics_pkg;

  typedef logic [1:0] tile_id_t;

  localparam tile_id_t TILE_TL = 2'd0;
  localparam tile_id_t TILE_TR = 2'd1;
  localparam tile_id_t TILE_BL = 2'd2;
  localparam tile_id_t TILE_BR = 2'd3;

  // Pixels written by the painter for one tile.
  localparam int unsigned TILE_PIXELS = 64;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PAINT_ON  = 3'd1,
    ST_HOLD_ON   = 3'd2,
    ST_PAINT_OFF = 3'd3,
    ST_GAP       = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  // Hold time for a step when the speed-up is enabled:
  // max(on_cycles - step_idx*on_step, on_min), never underflowing.
  function automatic logic [63:0] flash_hold(input logic [63:0] on_cycles,
                                             input logic [63:0] step_idx,
                                             input logic [63:0] on_step,
                                             input logic [63:0] on_min);
    logic [63:0] prod;
    logic [63:0] hold;
    prod = step_idx * on_step;
    if (prod >= on_cycles) begin
      hold = on_min;
    end else begin
      hold = on_cycles - prod;
      if (hold < on_min) begin
        hold = on_min;
      end else begin
        hold = hold;
      end
    end
    return hold;
  endfunction

endpackage

// File: rtl/tile_flash_sequencer_cycle_timer.sv
// cycle_timer: loadable down-counter that stops at zero. Loading N-1 and
// leaving the owning state on the zero flag gives exactly N clocks in it.
module cycle_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_r;

  // Load has priority; otherwise count down while enabled, saturating at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= '0;
    end else if (load) begin
      count_r <= value;
    end else if (en && (count_r != '0)) begin
      count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == '0);

endmodule

// File: rtl/tile_flash_sequencer.sv
// tile_flash_sequencer: plays back the stored Simon sequence through the
// tile painter (flash paint, hold, base paint, gap per entry).
// Optional feature macro FLASH_SPEEDUP_EN: hold shrinks by ON_STEP per step
// down to ON_MIN; when undefined every step holds ON_CYCLES.
module tile_flash_sequencer
  import graphics_pkg::*;
#(
  parameter int unsigned MAX_LEN    = 16,
  parameter int unsigned ON_CYCLES  = 25000000,
  parameter int unsigned GAP_CYCLES = 12500000,
  parameter int unsigned ON_STEP    = 2000000,
  parameter int unsigned ON_MIN     = 6250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       tile_valid,
  input  logic [1:0] tile_in,
  input  logic       start,
  input  logic       abort,
  input  logic       paint_done,
  output logic       paint_req,
  output logic [1:0] paint_tile,
  output logic       paint_flash,
  output logic       busy,
  output logic       done,
  output logic       full,
  output logic [4:0] count,
  output logic [4:0] step_idx
);

  localparam int unsigned MAX_DELAY = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int unsigned TW        = $clog2(MAX_DELAY + 1);
  localparam int unsigned IW        = $clog2(MAX_LEN);
  localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_CYCLES - 1);

  // Reject configurations the datapath cannot represent.
  if (MAX_LEN < 2 || MAX_LEN > 31) begin : g_bad_len
    $error("tile_flash_sequencer: MAX_LEN must be in 2..31");
  end
  if (ON_CYCLES < 1 || GAP_CYCLES < 1 || ON_MIN < 1 || ON_MIN > ON_CYCLES || ON_STEP > ON_CYCLES) begin : g_bad_timing
    $error("tile_flash_sequencer: inconsistent timing parameters");
  end

  seq_state_t    state_r, state_s;
  tile_id_t      seq_buf_r [0:MAX_LEN-1];
  logic [4:0]    count_r, step_idx_r;
  logic          abort_r;
  logic          paint_req_r, paint_flash_r, busy_r, done_r;
  tile_id_t      paint_tile_r;
  logic          timer_load_s, timer_en_s, timer_zero_s;
  logic [TW-1:0] timer_value_s;
  logic [63:0]   hold_s;
  logic          abort_any_s, in_paint_s;

`ifdef FLASH_SPEEDUP_EN
  assign hold_s = flash_hold(64'(ON_CYCLES), 64'(step_idx_r), 64'(ON_STEP), 64'(ON_MIN));
`else
  assign hold_s = 64'(ON_CYCLES);
`endif

  assign abort_any_s = abort | abort_r;
  assign in_paint_s  = (state_r == ST_PAINT_ON) || (state_r == ST_PAINT_OFF);

  cycle_timer #(.WIDTH(TW)) u_timer (
    .clock (clock),
    .reset (reset),
    .load  (timer_load_s),
    .value (timer_value_s),
    .en    (timer_en_s),
    .zero  (timer_zero_s)
  );

  // Next-state and timer control for the playback FSM.
  always_comb begin
    state_s       = state_r;
    timer_load_s  = 1'b0;
    timer_en_s    = 1'b0;
    timer_value_s = GAP_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = (count_r != 5'd0) ? ST_PAINT_ON : ST_FINISH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PAINT_ON: begin
        timer_value_s = TW'(hold_s - 64'd1);
        if (paint_done) begin
          if (abort_any_s) begin
            state_s = ST_PAINT_OFF;
          end else begin
            timer_load_s = 1'b1;
            state_s      = ST_HOLD_ON;
          end
        end else begin
          state_s = ST_PAINT_ON;
        end
      end
      ST_HOLD_ON: begin
        if (abort || timer_zero_s) begin
          state_s = ST_PAINT_OFF;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      ST_PAINT_OFF: begin
        if (paint_done) begin
          if (abort_any_s) begin
            state_s = ST_FINISH;
          end else begin
            timer_load_s = 1'b1;
            state_s      = ST_GAP;
          end
        end else begin
          state_s = ST_PAINT_OFF;
        end
      end
      ST_GAP: begin
        if (abort) begin
          state_s = ST_FINISH;
        end else if (timer_zero_s) begin
          state_s = (step_idx_r == (count_r - 5'd1)) ? ST_FINISH : ST_PAINT_ON;
        end else begin
          timer_en_s = 1'b1;
        end
      end
      ST_FINISH: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register, step index and latched abort.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      step_idx_r <= 5'd0;
      abort_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (state_s == ST_FINISH) begin
        step_idx_r <= 5'd0;
      end else if (state_r == ST_GAP && state_s == ST_PAINT_ON) begin
        step_idx_r <= step_idx_r + 5'd1;
      end else begin
        step_idx_r <= step_idx_r;
      end
      if (state_r == ST_FINISH) begin
        abort_r <= 1'b0;
      end else if (abort && state_r != ST_IDLE) begin
        abort_r <= 1'b1;
      end else begin
        abort_r <= abort_r;
      end
    end
  end

  // Entry count: start beats clear, clear beats append, appends drop when full.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_r <= 5'd0;
    end else if (state_r == ST_IDLE && !start) begin
      if (clear) begin
        count_r <= 5'd0;
      end else if (tile_valid && (count_r < 5'(MAX_LEN))) begin
        count_r <= count_r + 5'd1;
      end else begin
        count_r <= count_r;
      end
    end else begin
      count_r <= count_r;
    end
  end

  // Sequence storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clock) begin
    if (state_r == ST_IDLE && !start && !clear && tile_valid && (count_r < 5'(MAX_LEN))) begin
      seq_buf_r[count_r[IW-1:0]] <= tile_in;
    end else begin
      seq_buf_r <= seq_buf_r;
    end
  end

  // Registered outputs: painter request follows the state one cycle late and
  // drops right after paint_done; busy/done track the state being entered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      paint_req_r   <= 1'b0;
      paint_tile_r  <= TILE_TL;
      paint_flash_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      if (in_paint_s && !paint_done) begin
        paint_req_r   <= 1'b1;
        paint_tile_r  <= seq_buf_r[step_idx_r[IW-1:0]];
        paint_flash_r <= (state_r == ST_PAINT_ON);
      end else begin
        paint_req_r   <= 1'b0;
        paint_tile_r  <= TILE_TL;
        paint_flash_r <= 1'b0;
      end
      busy_r <= (state_s != ST_IDLE);
      done_r <= (state_s == ST_FINISH);
    end
  end

  assign paint_req   = paint_req_r;
  assign paint_tile  = paint_tile_r;
  assign paint_flash = paint_flash_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign full        = (count_r == 5'(MAX_LEN));
  assign count       = count_r;
  assign step_idx    = step_idx_r;

endmodule
